audio_pwm_out: RTL

AUDIO_PWM_OUT -- requirements
Module: audio_pwm_out

---
 rtl/audio_pwm_if.sv | 8 +
 rtl/audio_pwm_out.sv | 143 ++++++++++++++
 2 files changed

// File: rtl/audio_pwm_if.sv
// Mic-path sample stream feeding audio_pwm_out: one-cycle valid strobe plus PCM sample.
interface audio_pwm_if;
  logic        data_mic_valid;
  logic [15:0] data_mic;

  modport master (output data_mic_valid, output data_mic);
  modport slave  (input  data_mic_valid, input  data_mic);
endinterface

// File: rtl/audio_pwm_out.sv
// Sample FIFO + PWM audio DAC with prime/play sequencing and sticky overflow/underrun flags.
// Optional feature: define AUDIO_PWM_VOL_EN to add vol_i (arithmetic right-shift attenuation).
//
// state | meaning
// IDLE  | output off, FIFO flushed, counter held at 0
// PRIME | amplifier on, mid-scale duty, waiting for FIFO half full at a wrap
// PLAY  | one sample popped into the duty register per PWM period
module audio_pwm_out #(
  parameter int FIFO_DEPTH = 16,
  parameter int PWM_BITS   = 11
) (
  input  logic                            clk_i,
  input  logic                            rst_i,
  audio_pwm_if.slave                      mic,
  input  logic                            enable_i,
  input  logic                            clr_status_i,
`ifdef AUDIO_PWM_VOL_EN
  input  logic [2:0]                      vol_i,
`endif
  output logic                            pwm_audio_o,
  output logic                            pwm_sdaudio_o,
  output logic [$clog2(FIFO_DEPTH):0]     fifo_level_o,
  output logic                            overflow_o,
  output logic                            underrun_o
);

  localparam int AW = $clog2(FIFO_DEPTH);

  localparam logic [1:0] IDLE  = 2'd0;
  localparam logic [1:0] PRIME = 2'd1;
  localparam logic [1:0] PLAY  = 2'd2;

  localparam logic [PWM_BITS-1:0] DUTY_MID = {1'b1, {(PWM_BITS-1){1'b0}}};
  localparam logic [PWM_BITS-1:0] CNT_MAX  = '1;
  localparam logic [AW:0]         LVL_FULL = (AW+1)'(FIFO_DEPTH);
  localparam logic [AW:0]         LVL_HALF = (AW+1)'(FIFO_DEPTH / 2);

  logic [1:0]          state, state_nxt;
  logic [PWM_BITS-1:0] pwm_cnt, duty;
  logic [AW-1:0]       wr_ptr, rd_ptr;
  logic [AW:0]         level;
  logic signed [15:0]  mem [FIFO_DEPTH];

  logic wrap, fifo_empty, fifo_full;
  logic push_req, push, pop, ovf_evt, und_evt;
  logic signed [15:0]  pop_sample, pop_scaled;
  logic [15:0]         pop_ob;
  logic [PWM_BITS-1:0] pop_duty;

  assign wrap       = (pwm_cnt == CNT_MAX);
  assign fifo_empty = (level == '0);
  assign fifo_full  = (level == LVL_FULL);

  assign push_req = mic.data_mic_valid && enable_i;
  assign pop      = enable_i && (state == PLAY) && wrap && !fifo_empty;
  // a pop in the same cycle frees the slot, so a write while full still lands
  assign push     = push_req && (!fifo_full || pop);
  assign ovf_evt  = push_req && fifo_full && !pop;
  assign und_evt  = enable_i && (state == PLAY) && wrap && fifo_empty;

  assign pop_sample = mem[rd_ptr];
`ifdef AUDIO_PWM_VOL_EN
  assign pop_scaled = pop_sample >>> vol_i;
`else
  assign pop_scaled = pop_sample;
`endif
  // offset binary: flip the sign bit, keep the top PWM_BITS bits
  assign pop_ob   = pop_scaled ^ 16'h8000;
  assign pop_duty = PWM_BITS'(pop_ob >> (16 - PWM_BITS));

  always_comb begin
    state_nxt = state;
    if (!enable_i) begin
      state_nxt = IDLE;
    end else begin
      case (state)
        IDLE:    state_nxt = PRIME;
        PRIME:   if (wrap && (level >= LVL_HALF)) state_nxt = PLAY;
        PLAY:    if (und_evt) state_nxt = PRIME;
        default: state_nxt = IDLE;
      endcase
    end
  end

  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) begin
      state         <= IDLE;
      pwm_cnt       <= '0;
      duty          <= DUTY_MID;
      pwm_audio_o   <= 1'b0;
      pwm_sdaudio_o <= 1'b0;
    end else begin
      state         <= state_nxt;
      pwm_sdaudio_o <= (state_nxt != IDLE);
      pwm_audio_o   <= enable_i && (state != IDLE) && (pwm_cnt < duty);

      if ((state == IDLE) || (state_nxt == IDLE)) pwm_cnt <= '0;
      else                                        pwm_cnt <= pwm_cnt + PWM_BITS'(1);

      if (state != PLAY)  duty <= DUTY_MID;
      else if (pop)       duty <= pop_duty;
      else if (und_evt)   duty <= DUTY_MID;
    end
  end

  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      level  <= '0;
    end else if (!enable_i) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      level  <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + AW'(1);
      if (pop)  rd_ptr <= rd_ptr + AW'(1);
      case ({push, pop})
        2'b10:   level <= level + (AW+1)'(1);
        2'b01:   level <= level - (AW+1)'(1);
        default: level <= level;
      endcase
    end
  end

  always_ff @(posedge clk_i) begin
    if (push) mem[wr_ptr] <= mic.data_mic;
  end

  // a same-cycle event beats the clear
  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) begin
      overflow_o <= 1'b0;
      underrun_o <= 1'b0;
    end else begin
      overflow_o <= ovf_evt || (overflow_o && !clr_status_i);
      underrun_o <= und_evt || (underrun_o && !clr_status_i);
    end
  end

  assign fifo_level_o = level;

endmodule
